// File: rtl/core_input_skew_ctrl.sv
// Per-lane activation/weight FIFOs feeding the systolic array edge, with optional diagonal pop skew.
// Latency read->lane i data: 1+i cycles (skewed) or 1; no backpressure: full lanes drop pushes, empty lanes flag underflow.
module core_input_skew_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdat_i,
  output logic [DW-1:0] rdat_o,
  output logic          pop_ok_o,
  output logic          ovf_o,
  output logic          udf_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == CW'(DEPTH));
  assign pop_ok_o = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a full lane still accepts the push.
  assign push_ok  = push_i & (~full_o | pop_ok_o);
  assign ovf_o    = push_i & ~push_ok;
  assign udf_o    = pop_i & empty_o;
  assign rdat_o   = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_ok)  wptr_d = wptr_q + AW'(1);
    if (pop_ok_o) rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok_o)      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop_ok_o) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdat_i;
  end
endmodule

module core_input_skew_ctrl #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                write,
  input  logic [LANES*DW-1:0] ain,
  input  logic [LANES*DW-1:0] win,
  input  logic                read,
  input  logic                skew_en,
  output logic [LANES*DW-1:0] as,
  output logic [LANES*DW-1:0] ws,
  output logic [LANES-1:0]    avalid,
  output logic [LANES-1:0]    wvalid,
  output logic [LANES-1:0]    aemptys,
  output logic [LANES-1:0]    wemptys,
  output logic [LANES-1:0]    afulls,
  output logic [LANES-1:0]    wfulls,
  output logic                busy,
  output logic                ovf_err,
  output logic                udf_err
);
  logic [LANES-2:0]    skew_q;
  logic [LANES-1:0]    line;
  logic [LANES-1:0]    pstb;
  logic [DW-1:0]       a_head [LANES];
  logic [DW-1:0]       w_head [LANES];
  logic [LANES-1:0]    a_pop, w_pop, a_ovf, w_ovf, a_udf, w_udf;
  logic [LANES*DW-1:0] as_q, as_d, ws_q, ws_d;
  logic [LANES-1:0]    avalid_q, wvalid_q;
  logic                ovf_q, udf_q;

  // Stage j of the line holds read delayed j cycles; stage 0 is the live read.
  assign line = {skew_q, read & skew_en};

  always_comb begin
    pstb = '0;
    for (int i = 0; i < LANES; i++) pstb[i] = skew_en ? line[i] : read;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    core_input_skew_fifo #(.DW(DW), .DEPTH(DEPTH)) u_afifo (
      .clk(clk), .rst(rst), .push_i(write), .pop_i(pstb[i]),
      .wdat_i(ain[i*DW +: DW]), .rdat_o(a_head[i]), .pop_ok_o(a_pop[i]),
      .ovf_o(a_ovf[i]), .udf_o(a_udf[i]), .empty_o(aemptys[i]), .full_o(afulls[i])
    );
    core_input_skew_fifo #(.DW(DW), .DEPTH(DEPTH)) u_wfifo (
      .clk(clk), .rst(rst), .push_i(write), .pop_i(pstb[i]),
      .wdat_i(win[i*DW +: DW]), .rdat_o(w_head[i]), .pop_ok_o(w_pop[i]),
      .ovf_o(w_ovf[i]), .udf_o(w_udf[i]), .empty_o(wemptys[i]), .full_o(wfulls[i])
    );
  end

  always_comb begin
    as_d = as_q;
    ws_d = ws_q;
    for (int i = 0; i < LANES; i++) begin
      if (a_pop[i]) as_d[i*DW +: DW] = a_head[i];
      if (w_pop[i]) ws_d[i*DW +: DW] = w_head[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skew_q   <= '0;
      as_q     <= '0;
      ws_q     <= '0;
      avalid_q <= '0;
      wvalid_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      skew_q   <= line[LANES-2:0];
      as_q     <= as_d;
      ws_q     <= ws_d;
      avalid_q <= a_pop;
      wvalid_q <= w_pop;
      ovf_q    <= ovf_q | (|a_ovf) | (|w_ovf);
      udf_q    <= udf_q | (|a_udf) | (|w_udf);
    end
  end

  assign as      = as_q;
  assign ws      = ws_q;
  assign avalid  = avalid_q;
  assign wvalid  = wvalid_q;
  assign busy    = |skew_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
endmodule

// File: tb/tb_core_input_skew_ctrl.sv
// Scoreboard bench for core_input_skew_ctrl: a queue model of every lane FIFO predicts
// pops, flags and sticky errors; popped expectations are compared when the DUT presents data.
module tb_core_input_skew_ctrl;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                write, read, skew_en;
  logic [LANES*DW-1:0] ain, win, as, ws;
  logic [LANES-1:0]    avalid, wvalid, aemptys, wemptys, afulls, wfulls;
  logic                busy, ovf_err, udf_err;

  core_input_skew_ctrl #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .write(write), .ain(ain), .win(win), .read(read),
    .skew_en(skew_en), .as(as), .ws(ws), .avalid(avalid), .wvalid(wvalid),
    .aemptys(aemptys), .wemptys(wemptys), .afulls(afulls), .wfulls(wfulls),
    .busy(busy), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [DW-1:0]       ma [LANES][$];
  logic [DW-1:0]       mw [LANES][$];
  logic [DW-1:0]       ea [LANES][$];
  logic [DW-1:0]       ew [LANES][$];
  logic [LANES-1:0]    hist;
  logic [LANES*DW-1:0] hold_as, hold_ws;
  logic                m_ovf, m_udf, sk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_as"}, as, 64'd0);
    chk({tag, "_ws"}, ws, 64'd0);
    chk({tag, "_avalid"}, 64'(avalid), 64'd0);
    chk({tag, "_wvalid"}, 64'(wvalid), 64'd0);
    chk({tag, "_aemptys"}, 64'(aemptys), 64'hFF);
    chk({tag, "_wemptys"}, 64'(wemptys), 64'hFF);
    chk({tag, "_afulls"}, 64'(afulls), 64'd0);
    chk({tag, "_wfulls"}, 64'(wfulls), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf_err), 64'd0);
    chk({tag, "_udf"}, 64'(udf_err), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    write = 1'b0;
    read = 1'b0;
    #1;
    chk_reset(tag);
    for (int i = 0; i < LANES; i++) begin
      ma[i].delete(); mw[i].delete(); ea[i].delete(); ew[i].delete();
    end
    hist = '0; hold_as = '0; hold_ws = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_post"}, 64'(aemptys), 64'hFF);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic w, input logic r, input int k);
    logic [LANES-1:0] pst, eav, ewv, eae, ewe, eaf, ewf;
    logic [DW-1:0]    e;
    write = w; read = r; skew_en = sk;
    for (int i = 0; i < LANES; i++) begin
      ain[i*DW +: DW] = DW'(k + i);
      win[i*DW +: DW] = DW'(k + i) ^ 8'hA5;
    end
    hist[0] = r & sk;
    eav = '0; ewv = '0;
    for (int i = 0; i < LANES; i++) begin
      pst[i] = sk ? hist[i] : r;
      if (pst[i]) begin
        if (ma[i].size() > 0) begin ea[i].push_back(ma[i].pop_front()); eav[i] = 1'b1; end
        else m_udf = 1'b1;
        if (mw[i].size() > 0) begin ew[i].push_back(mw[i].pop_front()); ewv[i] = 1'b1; end
        else m_udf = 1'b1;
      end
      if (w) begin
        if (ma[i].size() < DEPTH) ma[i].push_back(ain[i*DW +: DW]); else m_ovf = 1'b1;
        if (mw[i].size() < DEPTH) mw[i].push_back(win[i*DW +: DW]); else m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    hist = hist << 1;
    chk("avalid", 64'(avalid), 64'(eav));
    chk("wvalid", 64'(wvalid), 64'(ewv));
    for (int i = 0; i < LANES; i++) begin
      if (eav[i]) begin
        e = ea[i].pop_front();
        hold_as[i*DW +: DW] = e;
        chk($sformatf("as_lane%0d", i), 64'(as[i*DW +: DW]), 64'(e));
      end
      if (ewv[i]) begin
        e = ew[i].pop_front();
        hold_ws[i*DW +: DW] = e;
        chk($sformatf("ws_lane%0d", i), 64'(ws[i*DW +: DW]), 64'(e));
      end
      eae[i] = (ma[i].size() == 0);
      ewe[i] = (mw[i].size() == 0);
      eaf[i] = (ma[i].size() == DEPTH);
      ewf[i] = (mw[i].size() == DEPTH);
    end
    chk("as_hold", as, hold_as);
    chk("ws_hold", ws, hold_ws);
    chk("aemptys", 64'(aemptys), 64'(eae));
    chk("wemptys", 64'(wemptys), 64'(ewe));
    chk("afulls", 64'(afulls), 64'(eaf));
    chk("wfulls", 64'(wfulls), 64'(ewf));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    chk("udf_err", 64'(udf_err), 64'(m_udf));
    if (sk) chk("busy", 64'(busy), 64'(|hist[LANES-1:1]));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; write = 1'b0; read = 1'b0; skew_en = 1'b0; sk = 1'b0;
    ain = '0; win = '0;
    hist = '0; hold_as = '0; hold_ws = '0; m_ovf = 1'b0; m_udf = 1'b0;
    #2;
    do_reset("reset");

    // fill every lane, then overflow once
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, k);
    chk("fill_afulls", 64'(afulls), 64'hFF);
    chk("fill_wfulls", 64'(wfulls), 64'hFF);
    chk("fill_no_ovf", 64'(ovf_err), 64'd0);
    step(1'b1, 1'b0, 16);
    chk("ovf_set", 64'(ovf_err), 64'd1);
    chk("ovf_still_full", 64'(afulls), 64'hFF);

    // single skewed wavefront: lane i valid only at cycle 1+i, data i
    sk = 1'b1;
    idle(1);
    step(1'b0, 1'b1, 0);
    chk("skew_l0_only", 64'(avalid), 64'h01);
    chk("skew_busy", 64'(busy), 64'd1);
    for (int c = 1; c < LANES; c++) begin
      step(1'b0, 1'b0, 0);
      chk($sformatf("skew_cycle%0d", c + 1), 64'(avalid), 64'(8'h01 << c));
      chk($sformatf("skew_data%0d", c), 64'(as[c*DW +: DW]), 64'(c));
    end
    idle(2);
    chk("skew_busy_done", 64'(busy), 64'd0);

    // aligned stream drains the remaining 15 entries
    sk = 1'b0;
    idle(1);
    for (int k = 0; k < DEPTH - 1; k++) step(1'b0, 1'b1, 0);
    idle(1);
    chk("stream_aemptys", 64'(aemptys), 64'hFF);
    chk("stream_wemptys", 64'(wemptys), 64'hFF);

    // push+pop on full lanes
    do_reset("reset2");
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 3 * k);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 100 + k);
    chk("pp_afulls", 64'(afulls), 64'hFF);
    chk("pp_no_ovf", 64'(ovf_err), 64'd0);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 0);

    // underflow on empty lanes
    step(1'b0, 1'b1, 0);
    chk("udf_avalid", 64'(avalid), 64'd0);
    chk("udf_set", 64'(udf_err), 64'd1);

    // reset in the middle of a skewed drain
    do_reset("reset3");
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 50 + k);
    sk = 1'b1;
    idle(1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0);
    do_reset("mid_rst");

    // random traffic, aligned then skewed
    sk = 1'b0;
    idle(1);
    for (int n = 0; n < 200; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)));
    idle(LANES);
    sk = 1'b1;
    idle(1);
    for (int n = 0; n < 200; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 255)));
    idle(LANES + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
